axis_branch_fifo: RTL



---
 rtl/axis_pkg.sv | 15 +
 rtl/axis_fifo_ram.sv | 26 ++
 rtl/axis_branch_fifo.sv | 122 ++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared AXI-Stream widths, beat type and FIFO depth default
package axis_pkg;

    localparam int AXIS_DATA_WIDTH = 32;
    localparam int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8;
    localparam int AXIS_FIFO_DEPTH = 16;

    // Field order is also the packing order used by the FIFO storage.
    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] tdata;
        logic [AXIS_KEEP_WIDTH-1:0] tkeep;
        logic                       tlast;
    } axis_beat_t;

endpackage

// File: rtl/axis_fifo_ram.sv
// rtl/axis_fifo_ram.sv - simple dual-port array, synchronous write, asynchronous read
module axis_fifo_ram #(
    parameter int WIDTH      = 37,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    // Contents are intentionally never reset; the pointers define validity.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_branch_fifo.sv
// rtl/axis_branch_fifo.sv - first-word-fall-through AXIS FIFO for one broadcast branch
module axis_branch_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH        = AXIS_DATA_WIDTH,
    parameter int KEEP_WIDTH        = AXIS_KEEP_WIDTH,
    parameter int DEPTH             = AXIS_FIFO_DEPTH,
    parameter int ALMOST_FULL_LEVEL = 12,
    localparam int ADDR_WIDTH       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ADDR_WIDTH:0]   level,
    output logic [ADDR_WIDTH:0]   frame_count,
    output logic                  almost_full
);

    localparam int                ENTRY_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] AF_LEVEL  = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] level_q, level_d;
    logic [ADDR_WIDTH:0] frame_count_q, frame_count_d;

    logic                   empty;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   frame_in;
    logic                   frame_out;
    logic [ENTRY_WIDTH-1:0] wr_entry;
    logic [ENTRY_WIDTH-1:0] head_entry;

    // Extra pointer MSB separates the full case from the empty case.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    end

    // Ready is a pure function of state so upstream may gate valid with it.
    assign s_axis_tready = !rst && !full;
    assign m_axis_tvalid = !rst && !empty;
    assign almost_full   = !rst && (level_q >= AF_LEVEL);

    assign push      = s_axis_tvalid && s_axis_tready;
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign frame_in  = push && s_axis_tlast;
    assign frame_out = pop && m_axis_tlast;

    assign wr_entry = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = head_entry;

    axis_fifo_ram #(
        .WIDTH      (ENTRY_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (head_entry)
    );

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        frame_count_d = frame_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + PTR_ONE;
            2'b01:   level_d = level_q - PTR_ONE;
            default: level_d = level_q;
        endcase

        case ({frame_in, frame_out})
            2'b10:   frame_count_d = frame_count_q + PTR_ONE;
            2'b01:   frame_count_d = frame_count_q - PTR_ONE;
            default: frame_count_d = frame_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            frame_count_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign level       = level_q;
    assign frame_count = frame_count_q;

endmodule
